mult_8_accumulator: RTL and testbench
=====================================

MULT_8_ACCUMULATOR -- requirements
Module: mult_8_accumulator

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 24, accumulator/result width in bits (legal range 17..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the per-group beat counter.
REQ-003 SHALL have port mult_8_acc_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port mult_8_acc_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mult_8_acc_clear, input, 1 bit: synchronous abort of the current group.
REQ-006 SHALL have port mult_8_acc_in_data, input, 16 bits: unsigned product taken from a mult_8 tile's mult_8_out.
REQ-007 SHALL have port mult_8_acc_in_valid, input, 1 bit: mult_8_acc_in_data is valid.
REQ-008 SHALL have port mult_8_acc_in_last, input, 1 bit: the current beat closes the group.
REQ-009 SHALL have port mult_8_acc_in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 SHALL have port mult_8_acc_out_data, output, ACC_WIDTH bits: the group sum.
REQ-011 SHALL have port mult_8_acc_out_count, output, CNT_WIDTH bits: number of beats in the group.
REQ-012 SHALL have port mult_8_acc_out_ovf, output, 1 bit: the group overflowed ACC_WIDTH.
REQ-013 SHALL have port mult_8_acc_out_valid, output, 1 bit: the result is held.
REQ-014 SHALL have port mult_8_acc_out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-015 SHALL implement FSM states IDLE (no beats, acc=0), ACCUM (at least 1 beat taken) and HOLD (result presented).
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in HOLD.
REQ-017 SHALL accept a beat on in_valid&&in_ready: acc += zero-extended in_data; count += 1; ovf |= carry out of ACC_WIDTH.
REQ-018 SHALL transition IDLE->ACCUM on an accepted non-last beat.
REQ-019 SHALL transition IDLE/ACCUM->HOLD on an accepted beat with in_last=1; out_valid SHALL rise the next cycle and out_data SHALL include that beat (latency 1).
REQ-020 SHALL treat a beat that makes count equal 2^CNT_WIDTH-1 as last regardless of in_last (forced close).
REQ-021 SHALL hold out_data, out_count and out_ovf stable while out_valid=1.
REQ-022 SHALL, in HOLD with out_ready=1, return to IDLE next cycle with acc, count and ovf cleared; in_ready SHALL be 1 that next cycle (no bypass of a beat during the HOLD cycle).
REQ-023 SHALL, on clear=1 in any state, go to IDLE next cycle, zero acc/count/ovf and drop out_valid; clear SHALL take priority over a simultaneous in_valid or out_ready, and the beat SHALL be dropped.
REQ-024 SHALL ignore in_data and in_last when in_valid=0; in_valid in HOLD SHALL NOT alter state.
REQ-025 SHALL drive out_data, out_count and out_ovf to 0 whenever out_valid=0.

Reset
REQ-026 SHALL, while mult_8_acc_reset=1, immediately force IDLE, acc=0, count=0, ovf=0, out_valid=0 and in_ready=0, independent of the clock.
REQ-027 SHALL drive in_ready=1 on the first clock edge after reset deasserts; reset mid-group SHALL discard the partial sum.

Configuration
REQ-028 SHALL honour macro MULT_8_ACC_SATURATE_EN: when defined, an overflowing add clamps acc to 2^ACC_WIDTH-1 and it stays there for the rest of the group; when undefined, acc wraps modulo 2^ACC_WIDTH; out_ovf SHALL behave identically in both builds.

Verification
REQ-029 SHALL cover: reset, then beats 0x0003, 0x0005, 0x0007 (last) with out_ready=1 -> out_data=15, out_count=3, out_ovf=0; out_valid high for exactly 1 cycle, one cycle after the last beat.
REQ-030 SHALL cover: ACC_WIDTH=17, beats 0xFFFF, 0xFFFF, 0xFFFF (last) -> out_ovf=1; out_data=0x0FFFD without the macro and 0x1FFFF with MULT_8_ACC_SATURATE_EN.
REQ-031 SHALL cover: a single beat 0x1234 with last and out_ready=0 for 5 cycles -> out_valid, out_data=0x1234 and in_ready=0 held stable; the result is released the cycle after out_ready=1.
REQ-032 SHALL cover: CNT_WIDTH=2, four beats of 1 with in_last=0 -> group closes after the third beat (out_count=3, out_data=3); the fourth beat starts a new group.
REQ-033 SHALL cover: clear asserted together with a valid beat in ACCUM -> next cycle IDLE, out_valid=0; the following group of a single 0x0010 beat yields 0x10.
REQ-034 SHALL cover: reset asserted asynchronously mid-group and in HOLD -> outputs 0 before the next clock edge; the next group sums correctly.

Source files
------------

// File: rtl/mult_8_accumulator.sv
// Sums a group of 16-bit unsigned mult_8 products into an ACC_WIDTH result with beat count and overflow flag.
// Optional macro MULT_8_ACC_SATURATE_EN: clamp the sum at 2^ACC_WIDTH-1 instead of wrapping.
module mult_8_accumulator #(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 mult_8_acc_clk,
    input  logic                 mult_8_acc_reset,
    input  logic                 mult_8_acc_clear,
    input  logic [15:0]          mult_8_acc_in_data,
    input  logic                 mult_8_acc_in_valid,
    input  logic                 mult_8_acc_in_last,
    output logic                 mult_8_acc_in_ready,
    output logic [ACC_WIDTH-1:0] mult_8_acc_out_data,
    output logic [CNT_WIDTH-1:0] mult_8_acc_out_count,
    output logic                 mult_8_acc_out_ovf,
    output logic                 mult_8_acc_out_valid,
    input  logic                 mult_8_acc_out_ready,
    output logic [1:0]           mult_8_acc_state_dbg
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // the result transfers on a rising edge where out_valid && out_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 ready_q, ready_d;

    logic                 accept;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 close;

    always_comb begin
        accept  = mult_8_acc_in_valid && ready_q && (state_q != HOLD);
        sum     = {1'b0, acc_q} + {{(ACC_WIDTH-15){1'b0}}, mult_8_acc_in_data};
        carry   = sum[ACC_WIDTH];
        cnt_inc = cnt_q + CNT_WIDTH'(1);
        // A beat that fills the counter closes the group even without in_last.
        close   = mult_8_acc_in_last || (cnt_inc == {CNT_WIDTH{1'b1}});

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
`ifdef MULT_8_ACC_SATURATE_EN
                    acc_d = (carry || ovf_q) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
                    acc_d = sum[ACC_WIDTH-1:0];
`endif
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_q | carry;
                    state_d = close ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (mult_8_acc_out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase

        if (mult_8_acc_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end

        // Registered so in_ready stays low through reset and rises on the first edge after it.
        ready_d = (state_d != HOLD);
    end

    always_ff @(posedge mult_8_acc_clk or posedge mult_8_acc_reset) begin
        if (mult_8_acc_reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        mult_8_acc_out_valid = (state_q == HOLD);
        mult_8_acc_in_ready  = ready_q;
        mult_8_acc_out_data  = mult_8_acc_out_valid ? acc_q : '0;
        mult_8_acc_out_count = mult_8_acc_out_valid ? cnt_q : '0;
        mult_8_acc_out_ovf   = mult_8_acc_out_valid ? ovf_q : 1'b0;
        mult_8_acc_state_dbg = state_q;
    end

endmodule

// File: tb/tb_mult_8_accumulator.sv
// Directed bench: a 17-bit accumulator for the group table and corner sequences, plus a 2-bit-count instance.
module tb_mult_8_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        clear = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [16:0] out_data;
  logic [7:0]  out_count;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  state_dbg;

  logic        c_clear = 1'b0;
  logic [15:0] c_in_data = '0;
  logic        c_in_valid = 1'b0;
  logic        c_in_last = 1'b0;
  logic        c_in_ready;
  logic [23:0] c_out_data;
  logic [1:0]  c_out_count;
  logic        c_out_ovf;
  logic        c_out_valid;
  logic        c_out_ready = 1'b1;
  logic [1:0]  c_state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_8_accumulator #(.ACC_WIDTH(17), .CNT_WIDTH(8)) dut (
    .mult_8_acc_clk(clk), .mult_8_acc_reset(rst), .mult_8_acc_clear(clear),
    .mult_8_acc_in_data(in_data), .mult_8_acc_in_valid(in_valid),
    .mult_8_acc_in_last(in_last), .mult_8_acc_in_ready(in_ready),
    .mult_8_acc_out_data(out_data), .mult_8_acc_out_count(out_count),
    .mult_8_acc_out_ovf(out_ovf), .mult_8_acc_out_valid(out_valid),
    .mult_8_acc_out_ready(out_ready), .mult_8_acc_state_dbg(state_dbg)
  );

  mult_8_accumulator #(.ACC_WIDTH(24), .CNT_WIDTH(2)) dut_c (
    .mult_8_acc_clk(clk), .mult_8_acc_reset(rst), .mult_8_acc_clear(c_clear),
    .mult_8_acc_in_data(c_in_data), .mult_8_acc_in_valid(c_in_valid),
    .mult_8_acc_in_last(c_in_last), .mult_8_acc_in_ready(c_in_ready),
    .mult_8_acc_out_data(c_out_data), .mult_8_acc_out_count(c_out_count),
    .mult_8_acc_out_ovf(c_out_ovf), .mult_8_acc_out_valid(c_out_valid),
    .mult_8_acc_out_ready(c_out_ready), .mult_8_acc_state_dbg(c_state_dbg)
  );

  typedef struct {
    int          n;
    logic [15:0] d0, d1, d2, d3;
    logic [16:0] exp_data;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: waits (bounded) for in_ready, presents one beat, returns at the next negedge.
  task automatic send(input logic [15:0] d, input logic last);
    int k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  task automatic expect_result(input logic [16:0] d, input logic [7:0] c, input logic o);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_data", {15'd0, out_data}, {15'd0, d});
    check("out_count", {24'd0, out_count}, {24'd0, c});
    check("out_ovf", {31'd0, out_ovf}, {31'd0, o});
  endtask

  task automatic expect_idle_outputs(input string name);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_data"}, {15'd0, out_data}, 32'd0);
    check({name, "_count"}, {24'd0, out_count}, 32'd0);
    check({name, "_ovf"}, {31'd0, out_ovf}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{3, 16'h0003, 16'h0005, 16'h0007, 16'h0000, 17'd15, 8'd3, 1'b0};
    vecs[1] = '{1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 17'h01234, 8'd1, 1'b0};
`ifdef MULT_8_ACC_SATURATE_EN
    vecs[2] = '{3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 17'h1FFFF, 8'd3, 1'b1};
    vecs[5] = '{4, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 17'h1FFFF, 8'd4, 1'b1};
`else
    vecs[2] = '{3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 17'h0FFFD, 8'd3, 1'b1};
    vecs[5] = '{4, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 17'h00000, 8'd4, 1'b1};
`endif
    vecs[3] = '{2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 17'd0, 8'd2, 1'b0};
    vecs[4] = '{2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 17'h10000, 8'd2, 1'b0};

    // Reset state, held before any clock edge.
    #3;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    expect_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    check("in_ready_before_first_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready_after_first_edge", {31'd0, in_ready}, 32'd1);

    // Table of groups, out_ready held high: result visible one cycle, then released.
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        logic [15:0] d;
        d = (i == 0) ? vecs[v].d0 : (i == 1) ? vecs[v].d1 : (i == 2) ? vecs[v].d2 : vecs[v].d3;
        if (i > 0) check("mid_group_no_valid", {31'd0, out_valid}, 32'd0);
        send(d, i == vecs[v].n - 1);
      end
      expect_result(vecs[v].exp_data, vecs[v].exp_cnt, vecs[v].exp_ovf);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      expect_idle_outputs("after_release");
      check("ready_after_release", {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held stable for 5 cycles, in_valid during HOLD ignored.
    out_ready = 1'b0;
    send(16'h1234, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h0F0F;
      in_last  = 1'b1;
      expect_result(17'h01234, 8'd1, 1'b0);
      check("hold_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    expect_result(17'h01234, 8'd1, 1'b0);
    @(negedge clk);
    expect_idle_outputs("backpressure_release");
    check("backpressure_ready", {31'd0, in_ready}, 32'd1);

    // Clear with a simultaneous valid beat in ACCUM drops the beat and the group.
    send(16'h0003, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0005;
    in_last  = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
    expect_idle_outputs("after_clear");
    check("clear_state_idle", {30'd0, state_dbg}, 32'd0);
    send(16'h0010, 1'b1);
    expect_result(17'h00010, 8'd1, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-group: outputs drop before the next edge.
    send(16'h0007, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_idle_outputs("async_rst_accum");
    check("async_rst_accum_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b1);
    expect_result(17'h00030, 8'd2, 1'b0);
    @(negedge clk);

    // Asynchronous reset while the result is held.
    out_ready = 1'b0;
    send(16'h0055, 1'b1);
    expect_result(17'h00055, 8'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_idle_outputs("async_rst_hold");
    check("async_rst_hold_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b1);
    expect_result(17'h00003, 8'd2, 1'b0);
    @(negedge clk);

    // CNT_WIDTH=2 instance: four beats of 1, third beat force-closes the group.
    for (int b = 0; b < 4; b++) begin
      int k = 0;
      while (!c_in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("c_in_ready", {31'd0, c_in_ready}, 32'd1);
      if (b == 3) check("c_released", {31'd0, c_out_valid}, 32'd0);
      c_in_valid = 1'b1;
      c_in_data  = 16'h0001;
      c_in_last  = 1'b0;
      @(negedge clk);
      c_in_valid = 1'b0;
      if (b == 2) begin
        check("c_forced_valid", {31'd0, c_out_valid}, 32'd1);
        check("c_forced_data", c_out_data, 32'd3);
        check("c_forced_count", {30'd0, c_out_count}, 32'd3);
        check("c_forced_ovf", {31'd0, c_out_ovf}, 32'd0);
        check("c_forced_ready", {31'd0, c_in_ready}, 32'd0);
      end
    end
    check("c_fourth_no_close", {31'd0, c_out_valid}, 32'd0);
    c_in_valid = 1'b1;
    c_in_data  = 16'h0002;
    c_in_last  = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    c_in_last  = 1'b0;
    check("c_new_group_valid", {31'd0, c_out_valid}, 32'd1);
    check("c_new_group_data", c_out_data, 32'd3);
    check("c_new_group_count", {30'd0, c_out_count}, 32'd2);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
